// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundle of every non-clock signal between the pipeline datapath and the
//   hazard/sequencing controller.
//   master : datapath side (drives decode/hazard inputs, receives enables).
//   slave  : controller side (receives hazard inputs, drives enables,
//            flushes, halted flag and performance counters).
//   CNT_W  : width of stall_cnt / flush_cnt.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      IFID_instruction;
  logic             IFID_readsRs;
  logic             IFID_readsRt;
  logic [2:0]       IDEX_writeRegSel;
  logic             IDEX_RegWrite;
  logic             IDEX_MemRead;
  logic             take_branch_PC;
  logic             dmem_stall;
  logic             dmem_done;
  logic             MEMWB_halt;
  logic             clr_cnt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output IFID_instruction, IFID_readsRs, IFID_readsRt, IDEX_writeRegSel,
           IDEX_RegWrite, IDEX_MemRead, take_branch_PC, dmem_stall,
           dmem_done, MEMWB_halt, clr_cnt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_flush, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  IFID_instruction, IFID_readsRs, IFID_readsRt, IDEX_writeRegSel,
           IDEX_RegWrite, IDEX_MemRead, take_branch_PC, dmem_stall,
           dmem_done, MEMWB_halt, clr_cnt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_flush, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Sequencing controller for the five-stage pipeline: decides each cycle
//   which pipeline registers advance, hold or load a NOP.
//   Ports:
//     clk         : rising-edge clock
//     rst         : synchronous, active-high reset
//     bus         : pipe_hazard_ctrl_if.slave (hazard inputs, stage
//                   enables/flushes, halted flag, stall/flush counters)
//     o_dbg_state : current FSM state (0 RUN, 1 FREEZE, 2 HALT)
//   Handshake: none; all control outputs are combinational from the current
//   state and inputs, and the pipeline registers sample them on the next edge.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_hazard_ctrl_if.slave     bus,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [2:0] w_rs;
  logic [2:0] w_rt;
  logic       w_load_use;
  logic       w_apply_run;
  logic       w_redirect_evt;
  logic       w_stall_evt;
  logic       w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic       w_ifid_flush, w_idex_flush;
  logic       w_unused;

  assign w_rs     = bus.IFID_instruction[10:8];
  assign w_rt     = bus.IFID_instruction[7:5];
  assign w_unused = ^{bus.IFID_instruction[15:11], bus.IFID_instruction[4:0]};

  assign w_load_use = bus.IDEX_MemRead & bus.IDEX_RegWrite &
                      ((bus.IFID_readsRs & (w_rs == bus.IDEX_writeRegSel)) |
                       (bus.IFID_readsRt & (w_rt == bus.IDEX_writeRegSel)));

  always_comb begin
    w_next         = r_state;
    w_apply_run    = 1'b0;
    w_redirect_evt = 1'b0;
    w_pc_en        = 1'b1;
    w_ifid_en      = 1'b1;
    w_idex_en      = 1'b1;
    w_exmem_en     = 1'b1;
    w_memwb_en     = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_flush   = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.MEMWB_halt) begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b0;
          w_next = ST_HALT;
        end else if (bus.dmem_stall && !bus.dmem_done) begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b0;
          w_next = ST_FREEZE;
        end else begin
          w_apply_run = 1'b1;
        end
      end
      ST_FREEZE: begin
        // MEM/WB is held, so a halt there cannot be new; only done matters.
        if (bus.dmem_done) begin
          w_apply_run = 1'b1;
          w_next      = ST_RUN;
        end else begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b0;
        end
      end
      ST_HALT: begin
        {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b0;
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase

    // Redirect squashes the younger instruction, so it masks load-use.
    if (w_apply_run) begin
      if (bus.take_branch_PC) begin
        w_ifid_flush   = 1'b1;
        w_idex_flush   = 1'b1;
        w_redirect_evt = 1'b1;
      end else if (w_load_use) begin
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_idex_flush = 1'b1;
      end
    end

    if (rst) begin
      w_next         = ST_RUN;
      w_redirect_evt = 1'b0;
      {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b11111;
      w_ifid_flush   = 1'b0;
      w_idex_flush   = 1'b0;
    end
  end

  assign w_stall_evt = !w_pc_en && (r_state != ST_HALT) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_redirect_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en      = w_pc_en;
  assign bus.ifid_en    = w_ifid_en;
  assign bus.idex_en    = w_idex_en;
  assign bus.exmem_en   = w_exmem_en;
  assign bus.memwb_en   = w_memwb_en;
  assign bus.ifid_flush = w_ifid_flush;
  assign bus.idex_flush = w_idex_flush;
  // During the reset cycle every output shows its reset value.
  assign bus.halted     = (r_state == ST_HALT) && !rst;
  assign bus.stall_cnt  = rst ? '0 : r_stall_cnt;
  assign bus.flush_cnt  = rst ? '0 : r_flush_cnt;
  assign o_dbg_state    = r_state;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage processor. Each cycle it decides which pipeline registers advance, hold, or are flushed to a NOP. It detects load-use hazards between the IF/ID and ID/EX stages and flushes younger instructions when execute redirects the PC. It also freezes the whole pipeline during multi-cycle data-memory accesses, parks the core on HALT, and keeps saturating stall and flush counters for performance analysis.

## Interface
- `CNT_W`, 16, width of the `stall_cnt` and `flush_cnt` performance counters.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `IFID_instruction`  in  16  instruction in IF/ID; Rs = [10:8], Rt = [7:5].
- `IFID_readsRs`  in  1  decoded instruction in IF/ID reads Rs.
- `IFID_readsRt`  in  1  decoded instruction in IF/ID reads Rt (including store data).
- `IDEX_writeRegSel`  in  3  destination register of the instruction in ID/EX.
- `IDEX_RegWrite`  in  1  instruction in ID/EX writes a register.
- `IDEX_MemRead`  in  1  instruction in ID/EX is a load.
- `take_branch_PC`  in  1  execute stage is redirecting the PC (branch taken, J, JAL, JR, JALR).
- `dmem_stall`  in  1  data memory cannot complete this cycle.
- `dmem_done`  in  1  data memory completes the pending access this cycle.
- `MEMWB_halt`  in  1  HALT instruction is in MEM/WB.
- `clr_cnt`  in  1  synchronously zero both counters.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  stage advance enables; all reset to 1.
- `ifid_flush`, `idex_flush`  out  1 each  load a NOP into the stage on this edge; both reset to 0.
- `halted`  out  1  core parked; registered; reset 0.
- `stall_cnt`  out  CNT_W  cycles lost to stalls and freezes; reset 0.
- `flush_cnt`  out  CNT_W  number of redirect flush events; reset 0.

## Operation
- States: RUN (reset state), FREEZE, HALT. Enables and flushes are combinational from the state and the inputs.
- Priority within RUN, highest first: halt, then freeze, then redirect, then load-use.
- Halt:
  - Trigger: `MEMWB_halt`=1.
  - All enables go to 0 and flushes to 0. Next state is HALT.
  - In HALT: all enables 0, `halted`=1. The core stays in HALT until `rst`; all other inputs are ignored.
- Freeze:
  - Trigger: `dmem_stall`=1 with `dmem_done`=0. All enables go to 0 and flushes to 0. Next state is FREEZE.
  - In FREEZE with `dmem_done`=0: all enables stay 0.
  - In FREEZE with `dmem_done`=1: behave as RUN for this cycle (apply the redirect and load-use rules), then go to RUN.
  - `dmem_stall` and `dmem_done` both 1: treat as done; no freeze.
  - `MEMWB_halt` is not evaluated in FREEZE, because MEM/WB is held.
- Redirect:
  - Trigger: `take_branch_PC`=1.
  - `ifid_flush`=1 and `idex_flush`=1. All enables stay 1, so the PC loads the target.
  - Load-use is suppressed in the same cycle, because the younger instruction is being squashed.
  - `flush_cnt` increments by 1.
- Load-use:
  - Trigger: `IDEX_MemRead` & `IDEX_RegWrite` & ((`IFID_readsRs` & Rs==`IDEX_writeRegSel`) | (`IFID_readsRt` & Rt==`IDEX_writeRegSel`)).
  - Response: `pc_en`=0, `ifid_en`=0, `idex_flush`=1 (bubble); `exmem_en` and `memwb_en` stay 1.
  - The stall lasts exactly one cycle. The bubble clears the condition, and the load value reaches execute through the MEM-EX forward.
- Counters:
  - `stall_cnt` increments in every cycle where `pc_en`=0 while not halted. This covers load-use and FREEZE cycles, including the cycle that enters FREEZE.
  - Both counters saturate at all-ones; they do not wrap.
  - `clr_cnt` zeroes both counters and takes priority over an increment in the same cycle.

## Timing
- Zero-latency control: enables and flushes respond in the same cycle as their inputs. Pipeline registers sample them on the next edge.
- State, `halted`, and the counters update on the rising edge. Counters reflect events up to and including the previous cycle.
- `rst` mid-freeze or mid-halt: state returns to RUN on the next edge. Enables are 1, flushes are 0, `halted` is 0, and both counters are 0.
- `rst` overrides every input during the cycle in which it is asserted. Outputs during that cycle are the reset values.

## Test plan
- Load-use: ID/EX holds `LD R3` (`IDEX_MemRead`=1, `IDEX_RegWrite`=1, `IDEX_writeRegSel`=3); IF/ID holds `ADD R1,R3,R2` with `IFID_readsRs`=1 → exactly 1 cycle of `pc_en`=0, `ifid_en`=0, `idex_flush`=1; `stall_cnt`=1 afterwards. Repeat with `IFID_readsRs`=0 → no stall.
- Redirect plus hazard: the load-use condition and `take_branch_PC`=1 in the same cycle → `ifid_flush`=1, `idex_flush`=1, `pc_en`=1; `flush_cnt`=1; `stall_cnt` unchanged.
- Freeze: `dmem_stall`=1 for 4 cycles, then `dmem_done`=1 → all enables 0 for 4 cycles, 1 in the done cycle; `stall_cnt`=4; state back to RUN.
- Redirect during freeze: `take_branch_PC` held at 1 throughout a 3-cycle freeze → no flush while frozen; flush asserted only in the `dmem_done` cycle; `flush_cnt`=1.
- Halt: `MEMWB_halt`=1 → all enables 0 from that cycle; `halted`=1 on the next edge and stays 1 under arbitrary stimulus; `rst` returns all outputs to their reset values.
- Saturation: set `CNT_W`=4, apply 20 stall cycles → `stall_cnt` stays at 15. Then assert `clr_cnt` together with a stall → `stall_cnt`=0.
